// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the two-port memory arbiter.
package mem_arbiter_pkg;

    // Sequencer states; encodings are shared with debug logic elsewhere.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    // Requester ids.
    typedef enum logic {
        ArbIc = 1'b0,
        ArbDc = 1'b1
    } arb_port_e;

    // Clear the byte-offset bits so the address points at the start of a line.
    // width must be a power of two.
    function automatic logic [31:0] line_align(logic [31:0] addr, int unsigned width);
        return addr & ~(32'(width) - 32'd1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned LineW = WIDTH * 8;

    logic             ic_req;
    logic [31:0]      ic_addr;
    logic             ic_ack;
    logic [LineW-1:0] ic_data;

    logic             dc_req;
    logic             dc_write;
    logic [31:0]      dc_addr;
    logic [LineW-1:0] dc_wdata;
    logic             dc_ack;
    logic [LineW-1:0] dc_rdata;

    logic [31:0]      mem_addr;
    logic [LineW-1:0] mem_wdata;
    logic             mem_read;
    logic             mem_write;
    logic [LineW-1:0] mem_rdata;

    // Arbiter view.
    modport master (
        input  ic_req, ic_addr, dc_req, dc_write, dc_addr, dc_wdata, mem_rdata,
        output ic_ack, ic_data, dc_ack, dc_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );

    // Requester and memory view.
    modport slave (
        output ic_req, ic_addr, dc_req, dc_write, dc_addr, dc_wdata, mem_rdata,
        input  ic_ack, ic_data, dc_ack, dc_rdata, mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser: on a tie the port not granted last wins.
module mem_arbiter_rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic      ic_req_i,
    input  logic      dc_req_i,
    input  arb_port_e last_i,
    output logic      valid_o,
    output arb_port_e id_o
);

    // Pick the single requester, or alternate on a tie.
    always_comb begin
        valid_o = ic_req_i | dc_req_i;
        id_o    = ArbIc;
        if (ic_req_i && dc_req_i) begin
            id_o = (last_i == ArbIc) ? ArbDc : ArbIc;
        end else if (dc_req_i) begin
            id_o = ArbDc;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported line memory between the instruction-fetch and data
// requesters. Grants round-robin, issues one command, waits LATENCY cycles and
// acks the granted port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic          busy
);

    localparam int unsigned LineW = WIDTH * 8;
    localparam int unsigned CntW  = $clog2(LATENCY + 1);

    arb_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    arb_port_e        last_q, last_d;
    arb_port_e        id_q, id_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [LineW-1:0] wdata_q, wdata_d;

    logic             gnt_valid;
    arb_port_e        gnt_id;

    mem_arbiter_rr_pick2 u_pick (
        .ic_req_i (bus.ic_req),
        .dc_req_i (bus.dc_req),
        .last_i   (last_q),
        .valid_o  (gnt_valid),
        .id_o     (gnt_id)
    );

    // Next-state logic: grant and latch in idle, then issue, wait, respond.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    wr_d    = (gnt_id == ArbDc) && bus.dc_write;
                    addr_d  = line_align((gnt_id == ArbDc) ? bus.dc_addr : bus.ic_addr, WIDTH);
                    wdata_d = bus.dc_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (LATENCY > 1) begin
                    state_d = StWait;
                    cnt_d   = CntW'(LATENCY - 1);
                end else begin
                    state_d = StResp;
                end
            end
            StWait: begin
                // Leave when the counter reaches 1; <= also guards a stray 0.
                if (cnt_q <= CntW'(1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter, round-robin pointer and request latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            last_q  <= ArbIc;
            id_q    <= ArbIc;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Outputs decoded from registered state only; read data is a pass-through.
    always_comb begin
        bus.mem_read  = (state_q == StIssue) && !wr_q;
        bus.mem_write = (state_q == StIssue) && wr_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.ic_ack    = (state_q == StResp) && (id_q == ArbIc);
        bus.dc_ack    = (state_q == StResp) && (id_q == ArbDc);
        bus.ic_data   = bus.mem_rdata;
        bus.dc_rdata  = bus.mem_rdata;
        busy          = (state_q != StIdle);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single-ported line memory between the instruction-fetch side (read-only) and the data side (read/write). It sits between the two cache/stage requesters and the `memory` instance, owns its `memread`/`memwrite`/`addr`/`wdata` pins, and returns responses through a req/ack handshake. It grants round-robin and models a configurable memory latency.

## Interface

**Parameters**
- `WIDTH`, 4: bytes per memory line. Line width is `WIDTH*8` bits.
- `LATENCY`, 1: cycles from the command cycle to the response cycle. Must be ≥1. 1 matches the registered-read memory.

**Ports** (line = `WIDTH*8` bits)
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `ic_req`  in  1  instruction read request; held until `ic_ack`.
- `ic_addr`  in  32  instruction byte address.
- `ic_ack`  out  1  one-cycle response strobe.
- `ic_data`  out  line  read line; valid only while `ic_ack`=1.
- `dc_req`  in  1  data request; held until `dc_ack`.
- `dc_write`  in  1  1 = write, 0 = read. Stable while `dc_req`=1.
- `dc_addr`  in  32  data byte address.
- `dc_wdata`  in  line  write line.
- `dc_ack`  out  1  one-cycle response strobe.
- `dc_rdata`  out  line  read line; valid only while `dc_ack`=1.
- `mem_addr`  out  32  to memory `addr`.
- `mem_wdata`  out  line  to memory `wdata`.
- `mem_read`  out  1  to memory `memread`.
- `mem_write`  out  1  to memory `memwrite`.
- `mem_rdata`  in  line  from memory `rdata`.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation

**States**
- IDLE: sample `ic_req`/`dc_req`.
  - Neither asserted: stay in IDLE.
  - One asserted: grant it.
  - Both asserted: grant the port not granted last.
  - On grant: latch the port id, address, write flag and wdata, then go to ISSUE.
- ISSUE (exactly 1 cycle): drive `mem_read` or `mem_write` from the latched request.
  - Go to WAIT if `LATENCY` > 1, else go to RESP.
- WAIT: down-counter loaded with `LATENCY-1` on entry. Go to RESP when it reaches 1.
  - Counter width is `$clog2(LATENCY+1)`.
- RESP (exactly 1 cycle): assert the granted port's ack, then return to IDLE.

**Datapath and arbitration**
- `mem_addr` = latched address with bits `[$clog2(WIDTH)-1:0]` forced to 0 (line-aligned). It is held from ISSUE through RESP and keeps its value in IDLE.
- `mem_wdata` = latched `dc_wdata`. For icache grants it is don't-care but stable.
- `ic_data` and `dc_rdata` are continuous copies of `mem_rdata`. No command is issued in WAIT or RESP, so `mem_rdata` is stable during ack.
- Writes follow the same ISSUE→WAIT→RESP sequence. `dc_ack` still pulses and `dc_rdata` is meaningless for a write.
- Round-robin pointer `last`: updated on every grant. Reset value is icache, so the first tie goes to dcache.
- Requests are sampled only in IDLE. Changes to req, addr or data after the grant are ignored until the next IDLE.
- A requester must drop `req` in the cycle after its ack unless it wants another access. A req still high in the next IDLE is treated as a new request.
- Out-of-range addresses are passed through unchecked; the memory truncates them.

**Reset**
- Asynchronous: all outputs go to 0 immediately, state = IDLE, `last` = icache, counter = 0.
- A reset during ISSUE drops `mem_write` at once. The in-flight access is lost and no ack is produced.
- The first grant is possible in the first clock edge after reset deasserts.

## Timing

- Request first seen in IDLE at cycle t:
  - ISSUE at t+1.
  - RESP (ack) at t+1+`LATENCY`.
  - IDLE at t+2+`LATENCY`.
- Minimum request-to-request spacing is `LATENCY`+2 cycles. Peak throughput is one line per `LATENCY`+2 cycles.
- `mem_read` and `mem_write` are never both 1, and are 1 only in ISSUE.
- `ic_ack` and `dc_ack` are never both 1.
- All outputs are registered or decoded from state only. There are no combinational paths from req inputs to outputs, apart from the `mem_rdata` pass-through.

## Structure

- State encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3) and port ids (`ARB_IC`=0, `ARB_DC`=1) go in `defines.v` as shared constants. The pipeline top also uses the port ids for debug.
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin chooser (inputs: two reqs and `last`; outputs: grant valid and grant id).
- The FSM, latency counter and latches stay in `mem_arbiter`.

## Test plan

- **icache read only:** `ic_req`=1, `ic_addr`=0x0000_0013, LATENCY=1.
  - `mem_read`=1 with `mem_addr`=0x0000_0010 at t+1.
  - `ic_ack`=1 at t+2 with `ic_data` = mem[4].
- **dcache write then read:** write 0xDEADBEEF to 0x20, then read 0x20.
  - `mem_write` pulses exactly once.
  - `dc_ack` arrives at t+2 for each access.
  - The read returns 0xDEADBEEF.
- **Tie after reset:** both reqs high at once.
  - Grant order is dcache, icache, dcache, icache.
  - Acks never overlap and are spaced 3 cycles apart at LATENCY=1.
- **LATENCY=4:** icache read.
  - ISSUE at t+1, WAIT for 3 cycles, `ic_ack` at t+5, `busy` high t+1..t+5.
  - A `dc_req` raised at t+2 is granted at t+6.
- **Reset mid-access:** `reset`=0 asserted during ISSUE of a dcache write.
  - `mem_write` drops asynchronously and no ack is produced.
  - After release, `ic_req`=1 completes normally with `last`=icache tie behaviour restored.
